// File: rtl/flit_sink.sv
// Ejection-side flit consumer: per-VC framing check, packet/flit counters, done and first-error capture.
// Optional destination check is enabled by defining FLIT_SINK_DESTCHK_EN.
//
// state  | meaning
// IDLE   | not armed, flit_ready=0, incoming flits ignored
// RUN    | accepting flits, counting packets toward expected
// DONE   | expected reached; any further accepted flit is OVERRUN
module flit_sink #(
    parameter int NUM_VC  = 2,
    parameter int DEST_W  = 14,
    parameter int CNT_W   = 10,
    parameter int FCNT_W  = 16,
    parameter int MY_ADDR = 0,
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [CNT_W-1:0]  expected,
    input  logic              flit_valid,
    output logic              flit_ready,
    input  logic              flit_head,
    input  logic              flit_tail,
    input  logic [VC_W-1:0]   flit_vc,
    input  logic [DEST_W-1:0] flit_dst,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [FCNT_W-1:0] flit_count,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_ORPHAN  = 3'd1;
    localparam logic [2:0] E_NESTED  = 3'd2;
    localparam logic [2:0] E_OVERRUN = 3'd3;
    localparam logic [2:0] E_DEST    = 3'd4;

    state_t            state, state_nxt;
    logic [NUM_VC-1:0] vc_open;
    logic [CNT_W-1:0]  exp_reg;
    logic [CNT_W-1:0]  pkt_inc;
    logic              accept;
    logic              is_open;
    logic [2:0]        flit_code;
    logic              pkt_end;

    assign accept  = flit_valid & flit_ready;
    assign pkt_inc = pkt_count + 1'b1;

`ifndef FLIT_SINK_DESTCHK_EN
    logic unused_dst;
    assign unused_dst = (^flit_dst) ^ (^MY_ADDR);
`endif

    // Classify the flit currently on the bus; framing takes priority over destination
    always_comb begin
        is_open   = vc_open[flit_vc];
        flit_code = E_NONE;
        if (state == S_DONE)
            flit_code = E_OVERRUN;
        else if (!flit_head && !is_open)
            flit_code = E_ORPHAN;
        else if (flit_head && is_open)
            flit_code = E_NESTED;
`ifdef FLIT_SINK_DESTCHK_EN
        else if (flit_head && (flit_dst != MY_ADDR[DEST_W-1:0]))
            flit_code = E_DEST;
`endif
        pkt_end = flit_tail && (flit_code == E_NONE);
    end

    // State register; flit_ready is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            flit_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            flit_ready <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        if (init) begin
            state_nxt = (expected == '0) ? S_DONE : S_RUN;
        end else begin
            case (state)
                S_RUN:
                    if (accept && pkt_end && (pkt_inc == exp_reg))
                        state_nxt = S_DONE;
                S_IDLE, S_DONE: state_nxt = state;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            flit_count <= '0;
            err        <= 1'b0;
            err_code   <= E_NONE;
            vc_open    <= '0;
            exp_reg    <= '0;
        end else if (init) begin
            pkt_count  <= '0;
            flit_count <= '0;
            err        <= 1'b0;
            err_code   <= E_NONE;
            vc_open    <= '0;
            exp_reg    <= expected;
        end else if (accept) begin
            if (flit_code != E_NONE) begin
                if (!err) begin
                    err      <= 1'b1;
                    err_code <= flit_code;
                end
            end else begin
                flit_count <= flit_count + 1'b1;
                if (flit_head && !flit_tail)
                    vc_open[flit_vc] <= 1'b1;
                else if (!flit_head && flit_tail)
                    vc_open[flit_vc] <= 1'b0;
                if (pkt_end)
                    pkt_count <= pkt_inc;
            end
        end
    end

endmodule

// File: tb/tb_flit_sink.sv
// Scoreboard bench for flit_sink: stimulus queues timestamped expected snapshots, a monitor compares them.
module tb_flit_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic [9:0]  expected;
    logic        flit_valid;
    logic        flit_ready;
    logic        flit_head;
    logic        flit_tail;
    logic [0:0]  flit_vc;
    logic [13:0] flit_dst;
    logic [9:0]  pkt_count;
    logic [15:0] flit_count;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          at;
        string       name;
        logic [9:0]  pk;
        logic [15:0] fc;
        logic        dn;
        logic        er;
        logic [2:0]  ec;
        logic        rdy;
    } exp_t;
    exp_t sb[$];

    flit_sink #(.NUM_VC(2), .DEST_W(14), .CNT_W(10), .FCNT_W(16), .MY_ADDR(5)) dut (
        .clk(clk), .rst(rst), .init(init), .expected(expected),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_head(flit_head), .flit_tail(flit_tail),
        .flit_vc(flit_vc), .flit_dst(flit_dst),
        .pkt_count(pkt_count), .flit_count(flit_count),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the head entry at the negedge of the cycle it was stamped for
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
            checks++; errors++;
            $display("FAIL %s: snapshot never sampled (cycle %0d)", sb[0].name, sb[0].at);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].at == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pkt_count !== e.pk || flit_count !== e.fc || done !== e.dn ||
                err !== e.er || err_code !== e.ec || flit_ready !== e.rdy) begin
                errors++;
                $display("FAIL %s: got pkt=%0d flit=%0d done=%0b err=%0b code=%0d rdy=%0b, want pkt=%0d flit=%0d done=%0b err=%0b code=%0d rdy=%0b",
                         e.name, pkt_count, flit_count, done, err, err_code, flit_ready,
                         e.pk, e.fc, e.dn, e.er, e.ec, e.rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input int pk, input int fc, input logic dn,
                              input logic er, input int ec, input logic rdy);
        exp_t e;
        e.at = cyc; e.name = name;
        e.pk = pk[9:0]; e.fc = fc[15:0]; e.dn = dn; e.er = er; e.ec = ec[2:0]; e.rdy = rdy;
        sb.push_back(e);
    endtask

    task automatic do_init(input int e);
        init = 1'b1; expected = e[9:0];
        tick();
        init = 1'b0;
    endtask

    task automatic send(input logic h, input logic t, input logic vc, input int dst);
        flit_valid = 1'b1; flit_head = h; flit_tail = t; flit_vc = vc; flit_dst = dst[13:0];
        tick();
        flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0;
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; expected = '0;
        flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0; flit_vc = '0; flit_dst = '0;
        tick(); tick();
        expect_now("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        send(1, 1, 0, 0);
        expect_now("idle_ignore", 0, 0, 0, 0, 0, 0);

        do_init(3);
        expect_now("init3", 0, 0, 0, 0, 0, 1);
        send(1, 1, 0, 0);
        send(1, 1, 0, 0);
        expect_now("single_2", 2, 2, 0, 0, 0, 1);
        send(1, 1, 0, 0);
        expect_now("single_3_done", 3, 3, 1, 0, 0, 1);

        do_init(2);
        expect_now("init2", 0, 0, 0, 0, 0, 1);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(1, 0, 1, 0);
        send(0, 1, 0, 0);
        expect_now("interleave_mid", 1, 4, 0, 0, 0, 1);
        send(0, 0, 1, 0);
        send(0, 1, 1, 0);
        expect_now("interleave_done", 2, 6, 1, 0, 0, 1);

        do_init(1);
        send(0, 0, 1, 0);
        expect_now("orphan", 0, 0, 0, 1, 1, 1);
        send(1, 0, 0, 0);
        send(1, 0, 0, 0);
        expect_now("nested_sticky", 0, 1, 0, 1, 1, 1);

        do_init(1);
        send(1, 1, 0, 0);
        expect_now("pkt_done1", 1, 1, 1, 0, 0, 1);
        send(1, 1, 1, 0);
        expect_now("overrun", 1, 1, 1, 1, 3, 1);

        do_init(0);
        expect_now("expect0_done", 0, 0, 1, 0, 0, 1);
        do_init(2);
        send(1, 0, 0, 0);
        expect_now("mid_packet", 0, 1, 0, 0, 0, 1);
        // Init and a flit on the same edge: init wins
        init = 1'b1; expected = 10'd2; flit_valid = 1'b1; flit_head = 1'b1; flit_tail = 1'b1; flit_vc = 1'b1;
        tick();
        init = 1'b0; flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0;
        expect_now("init_beats_flit", 0, 0, 0, 0, 0, 1);
        send(1, 0, 0, 0);
        rst = 1'b1; init = 1'b1; expected = 10'd1;
        tick();
        rst = 1'b0; init = 1'b0;
        expect_now("rst_beats_init", 0, 0, 0, 0, 0, 0);
        do_init(2);
        send(0, 1, 0, 0);
        expect_now("orphan_after_rst", 0, 0, 0, 1, 1, 1);

        do_init(2);
`ifdef FLIT_SINK_DESTCHK_EN
        send(1, 1, 0, 6);
        expect_now("dest_err", 0, 0, 0, 1, 4, 1);
        send(1, 1, 0, 5);
        expect_now("dest_ok_after", 1, 1, 0, 1, 4, 1);
`else
        send(1, 1, 0, 6);
        expect_now("dest_ignored", 1, 1, 0, 0, 0, 1);
        send(1, 1, 0, 5);
        expect_now("dest_ignored_2", 2, 2, 1, 0, 0, 1);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
